// File: rtl/mma_ctrl_pkg.sv
// Shared types and constants for the MMA launch controller.
package mma_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_START,
    ST_RUN,
    ST_RESP
  } mma_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/mma_launch_wdg.sv
// RUN-state watchdog: counts RUN cycles and flags expiry on the last allowed cycle.
module mma_launch_wdg #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + W'(1);
    end
  end

  // Combinational so the FSM can leave RUN on the same cycle the limit is hit.
  always_comb begin
    expired = en && (cnt == LAST);
  end

endmodule

// File: rtl/mma_launch_ctrl.sv
// Launch/response controller for the MMA engine. Optional RUN watchdog is built
// when MMA_LAUNCH_TIMEOUT_EN is defined.
module mma_launch_ctrl
  import mma_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 launch_valid,
  output logic                 launch_ready,
  input  logic                 launch_16bits_ia,
  output logic                 calc_start,
  output logic                 cfg_16bits_ia,
  input  logic                 sa_ready,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [1:0]           err_code,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [1:0]           done_err,
  output logic [CNT_WIDTH-1:0] run_cycles,
  output logic                 busy
);

  mma_state_e           state;
  logic [CNT_WIDTH-1:0] run_cycles_inc;

  always_comb begin
    run_cycles_inc = (run_cycles == '1) ? run_cycles : run_cycles + CNT_WIDTH'(1);
  end

`ifdef MMA_LAUNCH_TIMEOUT_EN
  logic wdg_expired;

  mma_launch_wdg #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ST_START),
    .en     (state == ST_RUN),
    .expired(wdg_expired)
  );
`else
  logic [31:0] unused_timeout_cycles;
  always_comb unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      launch_ready  <= 1'b1;
      calc_start    <= 1'b0;
      wb_ready      <= 1'b0;
      done_valid    <= 1'b0;
      done_err      <= ERR_OK;
      run_cycles    <= '0;
      cfg_16bits_ia <= 1'b0;
      busy          <= 1'b0;
    end else begin
      calc_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch_valid && launch_ready) begin
            cfg_16bits_ia <= launch_16bits_ia;
            run_cycles    <= '0;
            launch_ready  <= 1'b0;
            busy          <= 1'b1;
            state         <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (sa_ready) begin
            calc_start <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          run_cycles <= run_cycles_inc;
          wb_ready   <= 1'b1;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          run_cycles <= run_cycles_inc;
          // An engine result on the expiry cycle takes priority over the timeout.
          if (wb_valid) begin
            done_err   <= err_code;
            wb_ready   <= 1'b0;
            done_valid <= 1'b1;
            state      <= ST_RESP;
          end
`ifdef MMA_LAUNCH_TIMEOUT_EN
          else if (wdg_expired) begin
            done_err   <= ERR_TIMEOUT;
            wb_ready   <= 1'b0;
            done_valid <= 1'b1;
            state      <= ST_RESP;
          end
`endif
        end
        ST_RESP: begin
          if (done_ready) begin
            done_valid   <= 1'b0;
            launch_ready <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: begin
          launch_ready <= 1'b1;
          wb_ready     <= 1'b0;
          done_valid   <= 1'b0;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mma_launch_ctrl.sv
// Directed self-checking bench for mma_launch_ctrl (timeout cases run when
// MMA_LAUNCH_TIMEOUT_EN is defined).
module tb_mma_launch_ctrl;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          launch_valid;
  logic          launch_ready;
  logic          launch_16bits_ia;
  logic          calc_start;
  logic          cfg_16bits_ia;
  logic          sa_ready;
  logic          wb_valid;
  logic          wb_ready;
  logic [1:0]    err_code;
  logic          done_valid;
  logic          done_ready;
  logic [1:0]    done_err;
  logic [CW-1:0] run_cycles;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  always #5 clk = ~clk;

  mma_launch_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .launch_valid    (launch_valid),
    .launch_ready    (launch_ready),
    .launch_16bits_ia(launch_16bits_ia),
    .calc_start      (calc_start),
    .cfg_16bits_ia   (cfg_16bits_ia),
    .sa_ready        (sa_ready),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .err_code        (err_code),
    .done_valid      (done_valid),
    .done_ready      (done_ready),
    .done_err        (done_err),
    .run_cycles      (run_cycles),
    .busy            (busy)
  );

  always @(posedge clk) if (rst_n && calc_start) n_starts++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch a job with sa_ready high; returns in the first RUN cycle.
  task automatic launch_to_run(input logic ia);
    launch_valid = 1'b1;
    launch_16bits_ia = ia;
    sa_ready = 1'b1;
    step();
    launch_valid = 1'b0;
    step();
    step();
  endtask

  task automatic finish_job();
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; launch_valid = 1'b0; launch_16bits_ia = 1'b0; sa_ready = 1'b0;
    wb_valid = 1'b0; err_code = 2'b00; done_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_launch_ready", launch_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done_valid", done_valid, 0);
    check_eq("rst_run_cycles", run_cycles, 0);
    rst_n = 1'b1;
    step();
    check_eq("idle_launch_ready", launch_ready, 1);
    check_eq("idle_wb_ready", wb_ready, 0);

    // Basic job: START pulse 2 cycles after launch, wb_valid in the 10th RUN cycle.
    launch_valid = 1'b1; launch_16bits_ia = 1'b1; sa_ready = 1'b1;
    step();
    launch_valid = 1'b0; launch_16bits_ia = 1'b0;
    check_eq("basic_busy_wait", busy, 1);
    check_eq("basic_lr_low", launch_ready, 0);
    check_eq("basic_no_start_yet", calc_start, 0);
    check_eq("basic_cfg", cfg_16bits_ia, 1);
    step();
    check_eq("basic_calc_start", calc_start, 1);
    step();
    check_eq("basic_start_once", calc_start, 0);
    check_eq("basic_wb_ready", wb_ready, 1);
    repeat (9) step();
    wb_valid = 1'b1; err_code = 2'b00;
    step();
    wb_valid = 1'b0;
    check_eq("basic_done_valid", done_valid, 1);
    check_eq("basic_done_err", done_err, 0);
    check_eq("basic_run_cycles", run_cycles, 11);
    check_eq("basic_wb_ready_resp", wb_ready, 0);
    check_eq("basic_cfg_resp", cfg_16bits_ia, 1);
    finish_job();
    check_eq("basic_idle_lr", launch_ready, 1);
    check_eq("basic_idle_busy", busy, 0);
    check_eq("basic_rc_hold", run_cycles, 11);
    check_eq("basic_n_starts", n_starts, 1);

    // Engine busy, then error passthrough and backpressure.
    sa_ready = 1'b0; launch_valid = 1'b1; launch_16bits_ia = 1'b0;
    step();
    launch_valid = 1'b0;
    check_eq("busy_cfg", cfg_16bits_ia, 0);
    check_eq("busy_rc_clear", run_cycles, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("busy_no_start", calc_start, 0);
      check_eq("busy_flag", busy, 1);
    end
    sa_ready = 1'b1;
    step();
    check_eq("busy_start", calc_start, 1);
    step();
    wb_valid = 1'b1; err_code = 2'b01;
    step();
    check_eq("err_done_err", done_err, 2'b01);
    check_eq("err_run_cycles", run_cycles, 2);
    launch_valid = 1'b1; err_code = 2'b10;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("bp_done_valid", done_valid, 1);
      check_eq("bp_done_err", done_err, 2'b01);
      check_eq("bp_launch_ready", launch_ready, 0);
    end
    wb_valid = 1'b0; launch_valid = 1'b0;
    finish_job();
    check_eq("bp_n_starts", n_starts, 2);
    check_eq("bp_idle", busy, 0);

    // Reset asserted mid-RUN.
    launch_to_run(1'b1);
    check_eq("mid_wb_ready", wb_ready, 1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_wb_ready", wb_ready, 0);
    check_eq("arst_cfg", cfg_16bits_ia, 0);
    check_eq("arst_run_cycles", run_cycles, 0);
    check_eq("arst_calc_start", calc_start, 0);
    check_eq("arst_done_err", done_err, 0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_lr", launch_ready, 1);
    launch_to_run(1'b0);
    wb_valid = 1'b1; err_code = 2'b00;
    step();
    wb_valid = 1'b0;
    check_eq("post_rst_done", done_valid, 1);
    check_eq("post_rst_rc", run_cycles, 2);
    finish_job();

`ifdef MMA_LAUNCH_TIMEOUT_EN
    launch_to_run(1'b1);
    repeat (15) step();
    check_eq("to1_still_run", done_valid, 0);
    step();
    check_eq("to1_done_valid", done_valid, 1);
    check_eq("to1_done_err", done_err, 2'b11);
    check_eq("to1_run_cycles", run_cycles, 17);
    finish_job();
    launch_to_run(1'b1);
    repeat (15) step();
    wb_valid = 1'b1; err_code = 2'b01;
    step();
    wb_valid = 1'b0;
    check_eq("to2_done_err", done_err, 2'b01);
    check_eq("to2_run_cycles", run_cycles, 17);
    finish_job();
`else
    // No watchdog: RUN waits past any limit and run_cycles saturates.
    launch_to_run(1'b0);
    repeat (40) step();
    check_eq("nowdg_busy", busy, 1);
    check_eq("nowdg_no_done", done_valid, 0);
    repeat (260) step();
    wb_valid = 1'b1; err_code = 2'b10;
    step();
    wb_valid = 1'b0;
    check_eq("sat_run_cycles", run_cycles, 255);
    check_eq("sat_done_err", done_err, 2'b10);
    finish_job();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL tb_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mma_launch_ctrl.md
MMA_LAUNCH_CTRL -- requirements
Module: mma_launch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the RUN-state watchdog limit in clk cycles.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning the width of the run-cycle counter.
REQ-003 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port launch_valid, input, 1, meaning core requests an MMA job.
REQ-006 SHALL have port launch_ready, output, 1, meaning controller accepts a job.
REQ-007 SHALL have port launch_16bits_ia, input, 1, meaning activation width for the job; sampled on launch handshake.
REQ-008 SHALL have port calc_start, output, 1, meaning start pulse to the MMA engine.
REQ-009 SHALL have port cfg_16bits_ia, output, 1, meaning latched activation width to the engine.
REQ-010 SHALL have port sa_ready, input, 1, meaning engine idle.
REQ-011 SHALL have port wb_valid, input, 1, meaning engine result ready.
REQ-012 SHALL have port wb_ready, output, 1, meaning controller accepts the engine result.
REQ-013 SHALL have port err_code, input, 2, meaning engine status (00 = OK).
REQ-014 SHALL have port done_valid, output, 1, meaning job completion is reported to the core.
REQ-015 SHALL have port done_ready, input, 1, meaning core consumes the completion.
REQ-016 SHALL have port done_err, output, 2, meaning final job status.
REQ-017 SHALL have port run_cycles, output, CNT_WIDTH, meaning cycles spent in START+RUN for the last job.
REQ-018 SHALL have port busy, output, 1, meaning high whenever state != IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> WAIT_RDY -> START -> RUN -> RESP -> IDLE.
REQ-020 IDLE SHALL behave as follows:
- launch_ready=1.
- On launch_valid&&launch_ready: latch launch_16bits_ia into cfg_16bits_ia, clear run_cycles to 0, go WAIT_RDY.
REQ-021 WAIT_RDY SHALL go to START on the first cycle sa_ready=1, and stall indefinitely otherwise.
REQ-022 START SHALL assert calc_start=1 for exactly one cycle, then go RUN; calc_start SHALL be 0 in every other state.
REQ-023 RUN SHALL behave as follows:
- wb_ready=1.
- On wb_valid (handshake): capture err_code into done_err and go RESP.
- wb_ready SHALL be 0 in all other states.
REQ-024 RESP SHALL behave as follows:
- done_valid=1 and done_err held stable.
- On done_ready: go IDLE; the next launch is accepted no earlier than the following cycle.
REQ-025 run_cycles SHALL increment by 1 each cycle in START and RUN, saturate at all-ones, and hold its value from RESP until the next launch handshake.
REQ-026 cfg_16bits_ia SHALL remain stable from WAIT_RDY through RESP.
REQ-027 launch_valid while not in IDLE SHALL be ignored (launch_ready=0), and no job is queued.
REQ-028 wb_valid outside RUN SHALL be ignored.

Reset
REQ-029 On rst_n low, asynchronously and at any point mid-job, the block SHALL:
- enter IDLE;
- set calc_start=0, wb_ready=0, done_valid=0, done_err=00, run_cycles=0, cfg_16bits_ia=0, busy=0;
- set launch_ready=1 once reset deasserts.

Configuration
REQ-030 Macro MMA_LAUNCH_TIMEOUT_EN defined SHALL enable the watchdog:
- a counter is cleared on entry to RUN and increments each RUN cycle;
- when it reaches TIMEOUT_CYCLES-1 without wb_valid, done_err=11 and the FSM goes RESP;
- wb_valid in that same cycle SHALL win, capturing err_code.
REQ-031 Macro MMA_LAUNCH_TIMEOUT_EN undefined SHALL mean:
- no watchdog logic is present;
- RUN waits indefinitely;
- done_err=11 is never produced.

Structure
REQ-032 A shared package mma_ctrl_pkg SHALL hold:
- the FSM state enum;
- the error-code constants ERR_OK=2'b00 and ERR_TIMEOUT=2'b11.
REQ-033 The watchdog SHALL be a sub-module mma_launch_wdg (inputs clk, rst_n, clr, en; output expired), instantiated only under MMA_LAUNCH_TIMEOUT_EN.

Verification
REQ-034 Scenario basic job:
- Stimulus: launch with 16bits_ia=1; sa_ready=1; wb_valid after 10 RUN cycles with err_code=00.
- Required response: calc_start pulses once, 2 cycles after launch; done_err=00; cfg_16bits_ia=1; run_cycles=11.
REQ-035 Scenario engine busy:
- Stimulus: sa_ready=0 for 5 cycles after launch.
- Required response: calc_start stays 0 until the cycle after sa_ready rises; busy=1 throughout.
REQ-036 Scenario backpressure:
- Stimulus: done_ready=0 for 7 cycles; launch_valid held high meanwhile.
- Required response: done_valid and done_err stable; launch_ready=0; no second calc_start.
REQ-037 Scenario error passthrough:
- Stimulus: wb_valid with err_code=01.
- Required response: done_err=01.
REQ-038 Scenario timeout (macro on, TIMEOUT_CYCLES=16):
- Stimulus: case 1, no wb_valid; case 2, wb_valid on the expiry cycle.
- Required response: case 1, RESP with done_err=11 after 16 RUN cycles; case 2, err_code is captured.
REQ-039 Scenario reset mid-RUN:
- Stimulus: rst_n pulsed low while in RUN.
- Required response: all outputs at reset values immediately; a fresh launch then completes normally.
